// File: rtl/fifo_row_serializer.sv
// Row FIFO to word-stream serializer: pops one COLUMN-wide row and emits it column 0 first.
// Optional row counter output enabled by defining FIFO_ROW_SER_CNT_EN.
module fifo_row_serializer #(
    parameter int B      = 8,
    parameter int COLUMN = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data [COLUMN-1:0],
    output logic         fifo_rd,
    output logic [B-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
`ifdef FIFO_ROW_SER_CNT_EN
    ,
    output logic [15:0]  row_count
`endif
);

    localparam int CW = $clog2(COLUMN);
    localparam logic [CW-1:0] LAST_COL = CW'(COLUMN - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [B-1:0]  hold_q [COLUMN-1:0];
    logic [B-1:0]  hold_d [COLUMN-1:0];
    logic          at_last;
    logic          beat_xfer;

    assign at_last   = (col_q == LAST_COL);
    assign beat_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            hold_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            hold_q  <= hold_d;
        end
    end

    // A pop always loads a full row and restarts at column 0, whether from IDLE or on the last beat.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd) begin
                    hold_d  = fifo_r_data;
                    col_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_xfer) begin
                    if (at_last) begin
                        col_d = '0;
                        if (fifo_rd) begin
                            hold_d = fifo_r_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        fifo_rd   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                fifo_rd = ~fifo_empty;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = hold_q[col_q];
                out_last  = at_last;
                busy      = 1'b1;
                fifo_rd   = at_last & out_ready & ~fifo_empty;
            end
            default: begin
                fifo_rd = 1'b0;
            end
        endcase
        // The pop strobe is combinational, so it must be gated while reset is held.
        if (!reset) begin
            fifo_rd = 1'b0;
        end
    end

`ifdef FIFO_ROW_SER_CNT_EN
    logic [15:0] row_count_q, row_count_d;

    always_comb begin
        row_count_d = row_count_q;
        if (beat_xfer && at_last) begin
            row_count_d = row_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_count_q <= '0;
        end else begin
            row_count_q <= row_count_d;
        end
    end

    assign row_count = row_count_q;
`endif

endmodule

// File: tb/tb_fifo_row_serializer.sv
// Scoreboard bench for fifo_row_serializer: a queue-based FIFO model feeds rows,
// expected words are queued at push time and popped by an independent monitor.
module tb_fifo_row_serializer;

    localparam int B      = 8;
    localparam int COLUMN = 3;

    logic         clk;
    logic         reset;
    logic         fifo_empty;
    logic [B-1:0] fifo_r_data [COLUMN-1:0];
    logic         fifo_rd;
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
`ifdef FIFO_ROW_SER_CNT_EN
    logic [15:0]  row_count;
`endif

    fifo_row_serializer #(.B(B), .COLUMN(COLUMN)) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_rd     (fifo_rd),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
`ifdef FIFO_ROW_SER_CNT_EN
        ,
        .row_count   (row_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [B*COLUMN-1:0] fifo_q[$];
    logic [B:0]          exp_q[$];
    int                  held_rows = 0;
    int                  ready_mode = 1;
    logic [15:0]         cnt_model = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_row(input logic [B*COLUMN-1:0] row);
        fifo_q.push_back(row);
        for (int c = 0; c < COLUMN; c++) begin
            exp_q.push_back({(c == COLUMN - 1), row[c*B +: B]});
        end
    endtask

    function automatic logic [B*COLUMN-1:0] make_row(input logic [B-1:0] w0, input logic [B-1:0] w1,
                                                     input logic [B-1:0] w2);
        return {w2, w1, w0};
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || held_rows != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_output("drain_timeout", (n >= budget), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_word(input logic [B-1:0] word, input int budget, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            #3;
            if (out_valid && out_data == word) seen = 1'b1;
        end
        check_output("wait_word_timeout", seen, 1);
    endtask

    // Input driver: FIFO model outputs and downstream ready change only on the falling edge.
    initial begin : driver
        fifo_empty = 1'b1;
        out_ready  = 1'b0;
        for (int c = 0; c < COLUMN; c++) fifo_r_data[c] = '0;
        forever begin
            @(negedge clk);
            fifo_empty = (fifo_q.size() == 0);
            for (int c = 0; c < COLUMN; c++) begin
                fifo_r_data[c] = fifo_empty ? B'($urandom) : fifo_q[0][c*B +: B];
            end
            case (ready_mode)
                0:       out_ready = ($urandom_range(99) < 70);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples just before each rising edge and checks against the row-level model.
    initial begin : monitor
        logic         prev_stall;
        logic [B-1:0] prev_data;
        logic         prev_last;
        logic [B:0]   w;
        logic         exp_rd;
        logic         front_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                check_output("reset_fifo_rd", fifo_rd, 0);
                check_output("reset_out_valid", out_valid, 0);
                check_output("reset_busy", busy, 0);
                check_output("reset_out_data", out_data, 0);
                check_output("reset_out_last", out_last, 0);
`ifdef FIFO_ROW_SER_CNT_EN
                check_output("reset_row_count", row_count, 0);
`endif
                if (held_rows != 0) begin
                    while (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        if (w[B]) break;
                    end
                    held_rows = 0;
                end
                cnt_model  = 16'd0;
                prev_stall = 1'b0;
            end else begin
                front_last = (exp_q.size() > 0) ? exp_q[0][B] : 1'b0;
                exp_rd = !fifo_empty &&
                         (held_rows == 0 || (held_rows != 0 && out_ready && front_last));
                check_output("fifo_rd", fifo_rd, exp_rd);
                check_output("out_valid", out_valid, (held_rows != 0));
                check_output("busy", busy, (held_rows != 0));
`ifdef FIFO_ROW_SER_CNT_EN
                check_output("row_count", row_count, cnt_model);
`endif
                if (prev_stall) begin
                    check_output("stall_data", out_data, prev_data);
                    check_output("stall_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_beat", out_data, 0);
                        check_output("unexpected_beat_valid", 1, 0);
                    end else begin
                        w = exp_q.pop_front();
                        check_output("beat_data", out_data, w[B-1:0]);
                        check_output("beat_last", out_last, w[B]);
                        if (w[B] && held_rows > 0) begin
                            held_rows--;
                            cnt_model = cnt_model + 16'd1;
                        end
                    end
                end
                if (fifo_rd) begin
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    held_rows++;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    task automatic apply_stimulus();
        logic       seen;
        logic [7:0] b2b [6];
        b2b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset held with a non-empty FIFO, then release: pop must start in the first cycle.
        reset      = 1'b0;
        ready_mode = 1;
        push_row(make_row(8'h11, 8'h22, 8'h33));
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_output("release_fifo_rd", fifo_rd, 1);
        check_output("release_out_valid", out_valid, 0);
        wait_drain(50);
        check_output("single_idle_valid", out_valid, 0);
        check_output("single_idle_busy", busy, 0);

        // Back-to-back rows: six consecutive beats, second pop on the 0x33 beat.
        push_row(make_row(8'h11, 8'h22, 8'h33));
        push_row(make_row(8'h44, 8'h55, 8'h66));
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            #3;
            if (out_valid) seen = 1'b1;
        end
        check_output("b2b_start_timeout", seen, 1);
        for (int k = 0; k < 6; k++) begin
            check_output("b2b_valid", out_valid, 1);
            check_output("b2b_data", out_data, b2b[k]);
            check_output("b2b_rd", fifo_rd, (k == 2));
            if (k < 5) begin
                @(negedge clk);
                #3;
            end
        end
        wait_drain(50);

        // Backpressure while 0x22 is presented.
        push_row(make_row(8'h11, 8'h22, 8'h33));
        wait_word(8'h11, 20, seen);
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #3;
            check_output("bp_data", out_data, 8'h22);
            check_output("bp_valid", out_valid, 1);
            check_output("bp_rd", fifo_rd, 0);
        end
        ready_mode = 1;
        wait_drain(50);

        // Reset mid-row after the 0x11 beat; the next row must start at its column 0.
        push_row(make_row(8'h11, 8'h22, 8'h33));
        push_row(make_row(8'hAA, 8'hBB, 8'hCC));
        wait_word(8'h11, 20, seen);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("midrst_valid", out_valid, 0);
        check_output("midrst_busy", busy, 0);
        check_output("midrst_data", out_data, 0);
        check_output("midrst_rd", fifo_rd, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wait_word(8'hAA, 20, seen);
        wait_drain(50);

        // Randomised rows, gaps and backpressure.
        ready_mode = 0;
        for (int r = 0; r < 60; r++) begin
            push_row(make_row(B'($urandom), B'($urandom), B'($urandom)));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end
        wait_drain(2000);
        ready_mode = 1;

`ifdef FIFO_ROW_SER_CNT_EN
        check_output("cnt_total", row_count, cnt_model);
        force dut.row_count_q = 16'hFFFF;
        #1;
        release dut.row_count_q;
        cnt_model = 16'hFFFF;
        push_row(make_row(8'h01, 8'h02, 8'h03));
        wait_drain(50);
        check_output("cnt_wrap", row_count, 16'h0000);
`endif
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : main
        reset = 1'b0;
        apply_stimulus();
        check_output("final_exp_empty", exp_q.size(), 0);
        check_output("final_fifo_empty", fifo_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
